// File: rtl/watchdog_timer_core_if.sv
// Kick/config/status bundle between the watchdog driver side and watchdog_timer_core.
// WDT_WINDOW_EN adds win_cfg and early_kick.
interface watchdog_timer_core_if #(
  parameter int CNT_WIDTH = 32
);
  logic                 en;
  logic                 delta;
  logic                 cfg_load;
  logic [CNT_WIDTH-1:0] timeout_cfg;
  logic [CNT_WIDTH-1:0] warn_cfg;
  logic [CNT_WIDTH-1:0] count;
  logic [1:0]           state;
  logic                 bark;
  logic                 bite;
`ifdef WDT_WINDOW_EN
  logic [CNT_WIDTH-1:0] win_cfg;
  logic                 early_kick;

  modport master (
    output en, delta, cfg_load, timeout_cfg, warn_cfg, win_cfg,
    input  count, state, bark, bite, early_kick
  );
  modport slave (
    input  en, delta, cfg_load, timeout_cfg, warn_cfg, win_cfg,
    output count, state, bark, bite, early_kick
  );
`else
  modport master (
    output en, delta, cfg_load, timeout_cfg, warn_cfg,
    input  count, state, bark, bite
  );
  modport slave (
    input  en, delta, cfg_load, timeout_cfg, warn_cfg,
    output count, state, bark, bite
  );
`endif
endinterface

// File: rtl/watchdog_timer_core.sv
// Countdown watchdog: reloads on kick, level bark at warn threshold, BITE_LEN-cycle bite; arm-to-bite is timeout+1 edges.
// No backpressure: kicks are consumed every cycle. Define WDT_WINDOW_EN for the early-kick window check.
module watchdog_timer_core #(
  parameter int CNT_WIDTH   = 32,
  parameter int TIMEOUT     = 1000,
  parameter int WARN_THRESH = 100,
  parameter int BITE_LEN    = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  watchdog_timer_core_if.slave wd
);

  localparam int BCW = (BITE_LEN > 1) ? $clog2(BITE_LEN) : 1;
  localparam logic [BCW-1:0]       BITE_LAST = BCW'(BITE_LEN - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ARMED = 2'b01,
    S_WARN  = 2'b10,
    S_BITE  = 2'b11
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic [CNT_WIDTH-1:0] timeout_q, timeout_d;
  logic [CNT_WIDTH-1:0] warn_q, warn_d;
  logic [BCW-1:0]       bite_cnt_q, bite_cnt_d;
  logic                 bark_q, bark_d;
  logic                 bite_q, bite_d;
  logic                 win_bad;
`ifdef WDT_WINDOW_EN
  logic [CNT_WIDTH-1:0] win_q, win_d;
  logic                 early_q, early_d;

  assign win_bad = (win_q != '0) && (count_q > win_q);
`else
  assign win_bad = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    timeout_d  = timeout_q;
    warn_d     = warn_q;
    bite_cnt_d = bite_cnt_q;
    bark_d     = bark_q;
    bite_d     = bite_q;
`ifdef WDT_WINDOW_EN
    win_d      = win_q;
    early_d    = early_q;
`endif
    case (state_q)
      S_IDLE: begin
        count_d = '0;
        if (wd.cfg_load) begin
          timeout_d = (wd.timeout_cfg == '0) ? CNT_ONE : wd.timeout_cfg;
          warn_d    = wd.warn_cfg;
`ifdef WDT_WINDOW_EN
          win_d     = wd.win_cfg;
`endif
        end
        // Arming uses the register value held before any same-edge load.
        if (wd.en) begin
          state_d = S_ARMED;
          count_d = timeout_q;
`ifdef WDT_WINDOW_EN
          early_d = 1'b0;
`endif
        end
      end
      S_ARMED, S_WARN: begin
        if (!wd.en) begin
          state_d = S_IDLE;
          count_d = '0;
          bark_d  = 1'b0;
        end else if (wd.delta && !win_bad) begin
          state_d = S_ARMED;
          count_d = timeout_q;
          bark_d  = 1'b0;
        end else if (wd.delta || count_q == '0) begin
          // Expiry, or a kick that landed outside the window.
          state_d    = S_BITE;
          count_d    = '0;
          bark_d     = 1'b0;
          bite_d     = 1'b1;
          bite_cnt_d = BITE_LAST;
`ifdef WDT_WINDOW_EN
          if (wd.delta) early_d = 1'b1;
`endif
        end else begin
          if (state_q == S_ARMED && count_q <= warn_q) begin
            state_d = S_WARN;
            bark_d  = 1'b1;
          end
          count_d = count_q - CNT_ONE;
        end
      end
      default: begin
        count_d = '0;
        if (bite_cnt_q == '0) begin
          bite_d = 1'b0;
          if (wd.en) begin
            state_d = S_ARMED;
            count_d = timeout_q;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          bite_cnt_d = bite_cnt_q - 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      timeout_q  <= CNT_WIDTH'(TIMEOUT);
      warn_q     <= CNT_WIDTH'(WARN_THRESH);
      bite_cnt_q <= '0;
      bark_q     <= 1'b0;
      bite_q     <= 1'b0;
`ifdef WDT_WINDOW_EN
      win_q      <= '0;
      early_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      timeout_q  <= timeout_d;
      warn_q     <= warn_d;
      bite_cnt_q <= bite_cnt_d;
      bark_q     <= bark_d;
      bite_q     <= bite_d;
`ifdef WDT_WINDOW_EN
      win_q      <= win_d;
      early_q    <= early_d;
`endif
    end
  end

  assign wd.count = count_q;
  assign wd.state = state_q;
  assign wd.bark  = bark_q;
  assign wd.bite  = bite_q;
`ifdef WDT_WINDOW_EN
  assign wd.early_kick = early_q;
`endif

endmodule

// File: tb/tb_watchdog_timer_core.sv
// Directed + random bench for watchdog_timer_core against a phase/remaining-time model.
module tb_watchdog_timer_core;

  localparam int BITE_LEN = 4;
`ifdef WDT_WINDOW_EN
  localparam bit WIN_EN = 1'b1;
`else
  localparam bit WIN_EN = 1'b0;
`endif

  // Model phases; the 2-bit code the DUT reports is derived from these.
  localparam int PH_OFF = 0, PH_RUN = 1, PH_WARNING = 2, PH_RESET_REQ = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  watchdog_timer_core_if #(.CNT_WIDTH(32)) wif ();

  watchdog_timer_core #(
    .CNT_WIDTH(32), .TIMEOUT(1000), .WARN_THRESH(100), .BITE_LEN(BITE_LEN)
  ) dut (
    .clk (clk),
    .rst (rst),
    .wd  (wif.slave)
  );

  int n_asserts = 0;
  int n_fails   = 0;

  int          m_phase;
  logic [31:0] m_remaining;
  logic [31:0] m_timeout, m_warn, m_win;
  int          m_pulse_left;
  bit          m_early;

  function automatic logic [1:0] phase_code(input int ph);
    case (ph)
      PH_RUN:       return 2'b01;
      PH_WARNING:   return 2'b10;
      PH_RESET_REQ: return 2'b11;
      default:      return 2'b00;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_asserts++;
    assert (got === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic start_reset_req(input bit by_kick);
    m_phase      = PH_RESET_REQ;
    m_remaining  = 0;
    m_pulse_left = BITE_LEN;
    if (by_kick) m_early = 1'b1;
  endtask

  task automatic model_step(input bit r, input bit e, input bit d, input bit c,
                            input logic [31:0] t, input logic [31:0] w, input logic [31:0] wn);
    logic [31:0] old_timeout;
    if (r) begin
      m_phase = PH_OFF; m_remaining = 0; m_pulse_left = 0; m_early = 1'b0;
      m_timeout = 1000; m_warn = 100; m_win = 0;
      return;
    end
    old_timeout = m_timeout;
    case (m_phase)
      PH_OFF: begin
        if (c) begin
          m_timeout = (t == 0) ? 32'd1 : t;
          m_warn    = w;
          m_win     = wn;
        end
        if (e) begin
          m_phase = PH_RUN; m_remaining = old_timeout; m_early = 1'b0;
        end
      end
      PH_RUN, PH_WARNING: begin
        if (!e) begin
          m_phase = PH_OFF; m_remaining = 0;
        end else if (d) begin
          if (WIN_EN && m_win != 0 && m_remaining > m_win) start_reset_req(1'b1);
          else begin m_phase = PH_RUN; m_remaining = m_timeout; end
        end else if (m_remaining == 0) begin
          start_reset_req(1'b0);
        end else begin
          if (m_phase == PH_RUN && m_remaining <= m_warn) m_phase = PH_WARNING;
          m_remaining = m_remaining - 1;
        end
      end
      default: begin
        m_pulse_left--;
        if (m_pulse_left == 0) begin
          if (e) begin m_phase = PH_RUN; m_remaining = m_timeout; end
          else m_phase = PH_OFF;
        end
      end
    endcase
  endtask

  task automatic tick(input bit r, input bit e, input bit d, input bit c,
                      input logic [31:0] t, input logic [31:0] w, input logic [31:0] wn);
    rst             = r;
    wif.en          = e;
    wif.delta       = d;
    wif.cfg_load    = c;
    wif.timeout_cfg = t;
    wif.warn_cfg    = w;
`ifdef WDT_WINDOW_EN
    wif.win_cfg     = wn;
`endif
    @(posedge clk);
    model_step(r, e, d, c, t, w, wn);
    #1;
    chk("state", 32'(wif.state), 32'(phase_code(m_phase)));
    chk("count", wif.count, m_remaining);
    chk("bark", 32'(wif.bark), 32'(m_phase == PH_WARNING));
    chk("bite", 32'(wif.bite), 32'(m_phase == PH_RESET_REQ));
`ifdef WDT_WINDOW_EN
    chk("early_kick", 32'(wif.early_kick), 32'(m_early));
`endif
  endtask

  task automatic step(input bit e, input bit d);
    tick(1'b0, e, d, 1'b0, 32'd0, 32'd0, 32'd0);
  endtask

  task automatic load(input logic [31:0] t, input logic [31:0] w, input logic [31:0] wn);
    tick(1'b0, 1'b0, 1'b0, 1'b1, t, w, wn);
  endtask

  initial begin
    logic [31:0] min_cnt;
    int bark_seen, bite_seen;

    rst = 1'b1;
    wif.en = 1'b0; wif.delta = 1'b0; wif.cfg_load = 1'b0;
    wif.timeout_cfg = '0; wif.warn_cfg = '0;
`ifdef WDT_WINDOW_EN
    wif.win_cfg = '0;
`endif

    // Reset and default timeout
    repeat (3) tick(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
    chk("rst_state", 32'(wif.state), 32'd0);
    step(1'b1, 1'b0);
    chk("arm_default", wif.count, 32'd1000);
    step(1'b0, 1'b0);

    // Unkicked expiry with timeout 10, warn 3
    load(32'd10, 32'd3, 32'd0);
    step(1'b1, 1'b0);
    chk("arm10", wif.count, 32'd10);
    for (int k = 1; k <= 15; k++) begin
      step(1'b1, 1'b0);
      if (k <= 10) chk("countdown", wif.count, 32'(10 - k));
      if (k >= 8 && k <= 10) chk("bark_warn", 32'(wif.bark), 32'd1);
      if (k >= 11 && k <= 14) chk("bite_pulse", 32'(wif.bite), 32'd1);
      if (k == 15) begin
        chk("rearm_count", wif.count, 32'd10);
        chk("rearm_bite", 32'(wif.bite), 32'd0);
      end
    end

    // Regular kicks every 6 cycles
    min_cnt = '1; bark_seen = 0; bite_seen = 0;
    for (int i = 1; i <= 100; i++) begin
      step(1'b1, (i % 6) == 0);
      if (wif.count < min_cnt) min_cnt = wif.count;
      bark_seen += int'(wif.bark);
      bite_seen += int'(wif.bite);
    end
    chk("kick_min_ge4", 32'(min_cnt >= 32'd4), 32'd1);
    chk("kick_no_bark", 32'(bark_seen), 32'd0);
    chk("kick_no_bite", 32'(bite_seen), 32'd0);

    // Kick on the expiry edge, then kick inside WARN
    step(1'b1, 1'b1);
    repeat (10) step(1'b1, 1'b0);
    chk("at_zero", wif.count, 32'd0);
    step(1'b1, 1'b1);
    chk("zero_kick_cnt", wif.count, 32'd10);
    chk("zero_kick_state", 32'(wif.state), 32'd1);
    chk("zero_kick_bite", 32'(wif.bite), 32'd0);
    repeat (8) step(1'b1, 1'b0);
    chk("warn_entered", 32'(wif.bark), 32'd1);
    step(1'b1, 1'b1);
    chk("warn_kick_bark", 32'(wif.bark), 32'd0);

    // cfg_load outside IDLE, en drop in WARN, reset mid-bite
    tick(1'b0, 1'b1, 1'b0, 1'b1, 32'd50, 32'd3, 32'd0);
    step(1'b1, 1'b1);
    chk("cfg_ignored", wif.count, 32'd10);
    repeat (8) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    chk("en_drop_state", 32'(wif.state), 32'd0);
    chk("en_drop_bark", 32'(wif.bark), 32'd0);
    step(1'b1, 1'b0);
    repeat (12) step(1'b1, 1'b0);
    chk("in_bite", 32'(wif.bite), 32'd1);
    tick(1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
    chk("rst_bite", 32'(wif.bite), 32'd0);

    // Zero timeout stored as 1
    load(32'd0, 32'd0, 32'd0);
    step(1'b1, 1'b0);
    chk("timeout0", wif.count, 32'd1);
    step(1'b0, 1'b0);

`ifdef WDT_WINDOW_EN
    load(32'd10, 32'd3, 32'd5);
    step(1'b1, 1'b0);
    repeat (2) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    chk("win_bite", 32'(wif.state), 32'd3);
    chk("win_early", 32'(wif.early_kick), 32'd1);
    repeat (4) step(1'b1, 1'b0);
    chk("win_early_hold", 32'(wif.early_kick), 32'd1);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    chk("win_early_clr", 32'(wif.early_kick), 32'd0);
    repeat (6) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    chk("win_ok_cnt", wif.count, 32'd10);
    chk("win_ok_early", 32'(wif.early_kick), 32'd0);
    step(1'b0, 1'b0);
`endif

    // Random traffic
    for (int n = 0; n < 2000; n++) begin
      tick($urandom_range(0, 199) == 0, $urandom_range(0, 19) != 0,
           $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0,
           32'($urandom_range(0, 20)), 32'($urandom_range(0, 20)),
           32'($urandom_range(0, 15)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule

// File: doc/watchdog_timer_core.md
Name: watchdog_timer_core

Overview:
- Countdown watchdog that consumes the single-cycle `delta` kick pulse produced by the watchdog timer driver.
- Arms on `en` and reloads on every kick.
- Raises a level `bark` warning when the count falls to the warning threshold.
- Emits a fixed-length `bite` pulse (system reset request) when the count expires without a kick.
- Sits directly downstream of the driver, between it and the reset/interrupt controller.

Parameters:
- CNT_WIDTH, 32, width of counter and config registers.
- TIMEOUT, 1000, reset value of the timeout register (cycles).
- WARN_THRESH, 100, reset value of the warning-threshold register.
- BITE_LEN, 4, bite pulse length in cycles (>=1).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- en  in  1  watchdog enable (level).
- delta  in  1  kick pulse from the driver.
- cfg_load  in  1  latch timeout_cfg/warn_cfg (honoured in IDLE only).
- timeout_cfg  in  CNT_WIDTH  new timeout value.
- warn_cfg  in  CNT_WIDTH  new warning threshold.
- count  out  CNT_WIDTH  current countdown value.
- state  out  2  00 IDLE, 01 ARMED, 10 WARN, 11 BITE.
- bark  out  1  warning level; high only in WARN.
- bite  out  1  reset request; high only in BITE.

Behaviour:
- Single clock. Reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset values:
  - state=IDLE, count=0, bark=0, bite=0.
  - timeout_reg=TIMEOUT, warn_reg=WARN_THRESH, bite_cnt=0.
- Config:
  - cfg_load in IDLE latches timeout_reg/warn_reg at that edge.
  - cfg_load in any other state is ignored.
  - A timeout_cfg value of 0 is stored as 1.
- IDLE:
  - count=0.
  - en=1 at an edge -> ARMED and count<=timeout_reg.
  - delta is ignored.
- ARMED and WARN, per edge, evaluated in priority order:
  1. en=0 -> IDLE, count<=0, bark<=0.
  2. delta=1 -> count<=timeout_reg, state<=ARMED, bark<=0. A kick wins over simultaneous expiry or warning entry.
  3. count==0 -> BITE, bite<=1, bark<=0, bite_cnt<=BITE_LEN-1.
  4. ARMED and count<=warn_reg -> WARN, bark<=1, count<=count-1.
  5. Otherwise count<=count-1.
- Arm-to-bite latency is timeout_reg+1 edges.
- Comparison rule: warn_reg>=timeout_reg enters WARN on the first edge after arming.
- BITE:
  - delta and cfg_load are ignored; count holds 0.
  - bite_cnt decrements each edge.
  - At bite_cnt==0: bite<=0; if en=1, go to ARMED with count<=timeout_reg, else go to IDLE.
  - bite is high for exactly BITE_LEN cycles.
  - en=0 mid-BITE does not truncate the pulse.
- Arithmetic:
  - Counter is unsigned. It never decrements below 0 and does not wrap.
- Reset mid-operation:
  - rst dominates all inputs; everything returns to reset values at that edge.
  - Config registers return to their parameter defaults.
  - A bite in progress is truncated.

Optional Feature:
- Macro: WDT_WINDOW_EN
- With the macro defined:
  - Adds port `win_cfg` (in, CNT_WIDTH), latched with cfg_load; reset value 0.
  - Adds output `early_kick` (1 bit).
  - A delta in ARMED/WARN while count>win_reg is a window violation: immediate BITE with no reload.
  - early_kick is set at that edge and stays high until rst or the next arm from IDLE.
  - win_reg=0 disables the window check.
- Without the macro:
  - No extra ports.
  - Any kick in ARMED/WARN is accepted.

Test Plan:
1. rst=1 for 3 cycles, en=0 -> state=00, count=0, bark=0, bite=0; timeout_reg=1000 checked via arm -> count=1000.
2. cfg_load timeout=10, warn=3, then en=1, no kicks:
   - count 10..0 over edges 0..10.
   - WARN and bark=1 from edge 8.
   - bite=1 on edges 11-14.
   - re-armed at count=10 on edge 15.
3. Same config, delta every 6 cycles for 100 cycles -> count never below 4; bark=0 and bite=0 throughout.
4. delta at exactly count==0 (same edge as expiry) -> count=10, state ARMED, no bite. Kick in WARN -> bark drops the next edge.
5. cfg_load timeout=50 while ARMED -> ignored, next reload still 10. en=0 mid-WARN -> IDLE, bark=0 at that edge. rst during BITE -> bite=0 at that edge.
6. (WDT_WINDOW_EN) timeout=10, win=5: kick at count=8 -> BITE and early_kick=1; kick at count=4 -> accepted, early_kick stays 0.
